// File: rtl/l2_req_out_packetizer.sv
// l2_req_out_packetizer
// Turns one L2 coherence request into a NoC packet on the request plane.
// The packet is a header flit, then an address flit, then one data flit per
// line word for PUTM only. Every output is driven straight from a register.
module l2_req_out_packetizer #(
  parameter int WORD_W         = 64,
  parameter int WORDS_PER_LINE = 2,
  parameter int LINE_ADDR_W    = 28,
  parameter int TILE_ID_W      = 4,
  parameter int FLIT_W         = WORD_W + 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             l2_req_out_valid,
  output logic                             l2_req_out_ready,
  input  logic [1:0]                       l2_req_out_data_coh_msg,
  input  logic [1:0]                       l2_req_out_data_hprot,
  input  logic [LINE_ADDR_W-1:0]           l2_req_out_data_addr,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] l2_req_out_data_line,
  input  logic [TILE_ID_W-1:0]             cfg_src_id,
  input  logic [TILE_ID_W-1:0]             cfg_dst_id,
  output logic                             noc_out_valid,
  input  logic                             noc_out_ready,
  output logic [FLIT_W-1:0]                noc_out_data,
  output logic [15:0]                      pkt_cnt
);

  localparam int LINE_W = WORD_W * WORDS_PER_LINE;
  localparam int IDX_W  = $clog2(WORDS_PER_LINE);

  localparam logic [1:0]       MSG_PUTM = 2'd3;
  localparam logic [3:0]       N_SHORT  = 4'd1;
  localparam logic [3:0]       N_PUTM   = 4'(1 + WORDS_PER_LINE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, HEAD, ADDR, DATA} state_t;

  state_t                 state;
  logic [1:0]             msg_p0;
  logic [LINE_ADDR_W-1:0] addr_p0;
  logic [LINE_W-1:0]      line_p0;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_nxt;
  logic                   req_take;
  logic                   unused_hprot;

  // hprot[1] carries no meaning on the request plane.
  assign unused_hprot = l2_req_out_data_hprot[1];
  assign req_take     = l2_req_out_valid && l2_req_out_ready;
  assign idx_nxt      = idx + 1'b1;

  function automatic logic [WORD_W-1:0] head_payload(
    input logic [1:0]           msg,
    input logic                 prot,
    input logic [TILE_ID_W-1:0] src,
    input logic [TILE_ID_W-1:0] dst
  );
    logic [WORD_W-1:0] p;
    p                  = '0;
    p[1:0]             = msg;
    p[2]               = prot;
    p[4 +: TILE_ID_W]  = src;
    p[8 +: TILE_ID_W]  = dst;
    p[12 +: 4]         = (msg == MSG_PUTM) ? N_PUTM : N_SHORT;
    return p;
  endfunction

  function automatic logic [WORD_W-1:0] addr_payload(input logic [LINE_ADDR_W-1:0] a);
    logic [WORD_W-1:0] p;
    p                  = '0;
    p[LINE_ADDR_W-1:0] = a;
    return p;
  endfunction

  function automatic logic [WORD_W-1:0] line_word(
    input logic [LINE_W-1:0] line,
    input logic [IDX_W-1:0]  i
  );
    return line[i*WORD_W +: WORD_W];
  endfunction

  function automatic logic [FLIT_W-1:0] make_flit(
    input logic              tail,
    input logic              head,
    input logic [WORD_W-1:0] payload
  );
    return {tail, head, payload};
  endfunction

  // Request capture: the packet only ever sees what was present at the handshake.
  always_ff @(posedge clk) begin
    if (req_take) begin
      msg_p0  <= l2_req_out_data_coh_msg;
      addr_p0 <= l2_req_out_data_addr;
      line_p0 <= l2_req_out_data_line;
    end
  end

  // Packet FSM: each state loads the next flit into the output register on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      l2_req_out_ready <= 1'b0;
      noc_out_valid    <= 1'b0;
      noc_out_data     <= '0;
      pkt_cnt          <= '0;
      idx              <= '0;
    end else begin
      case (state)
        IDLE: begin
          l2_req_out_ready <= 1'b1;
          if (req_take) begin
            l2_req_out_ready <= 1'b0;
            noc_out_valid    <= 1'b1;
            noc_out_data     <= make_flit(1'b0, 1'b1,
                                          head_payload(l2_req_out_data_coh_msg,
                                                       l2_req_out_data_hprot[0],
                                                       cfg_src_id, cfg_dst_id));
            idx              <= '0;
            state            <= HEAD;
          end
        end
        HEAD: begin
          if (noc_out_ready) begin
            noc_out_data <= make_flit(msg_p0 != MSG_PUTM, 1'b0, addr_payload(addr_p0));
            state        <= ADDR;
          end
        end
        ADDR: begin
          if (noc_out_ready) begin
            if (msg_p0 == MSG_PUTM) begin
              noc_out_data <= make_flit(IDX_LAST == '0, 1'b0, line_word(line_p0, '0));
              idx          <= '0;
              state        <= DATA;
            end else begin
              noc_out_valid    <= 1'b0;
              noc_out_data     <= '0;
              pkt_cnt          <= pkt_cnt + 16'd1;
              l2_req_out_ready <= 1'b1;
              state            <= IDLE;
            end
          end
        end
        DATA: begin
          if (noc_out_ready) begin
            if (idx == IDX_LAST) begin
              noc_out_valid    <= 1'b0;
              noc_out_data     <= '0;
              pkt_cnt          <= pkt_cnt + 16'd1;
              l2_req_out_ready <= 1'b1;
              state            <= IDLE;
            end else begin
              idx          <= idx_nxt;
              noc_out_data <= make_flit(idx_nxt == IDX_LAST, 1'b0, line_word(line_p0, idx_nxt));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_req_out_packetizer.sv
// Self-checking bench for l2_req_out_packetizer: expected flits are queued when a
// request is driven and compared against flits the router side accepts.
module tb_l2_req_out_packetizer;

  localparam int WORD_W      = 64;
  localparam int WPL         = 2;
  localparam int LINE_ADDR_W = 28;
  localparam int TILE_ID_W   = 4;
  localparam int FLIT_W      = WORD_W + 2;
  localparam int LINE_W      = WORD_W * WPL;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   l2_req_out_valid = 1'b0;
  logic                   l2_req_out_ready;
  logic [1:0]             l2_req_out_data_coh_msg = '0;
  logic [1:0]             l2_req_out_data_hprot = '0;
  logic [LINE_ADDR_W-1:0] l2_req_out_data_addr = '0;
  logic [LINE_W-1:0]      l2_req_out_data_line = '0;
  logic [TILE_ID_W-1:0]   cfg_src_id = 4'd3;
  logic [TILE_ID_W-1:0]   cfg_dst_id = 4'd5;
  logic                   noc_out_valid;
  logic                   noc_out_ready = 1'b0;
  logic [FLIT_W-1:0]      noc_out_data;
  logic [15:0]            pkt_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt  = '0;
  logic [FLIT_W-1:0] exp_q[$];
  logic [FLIT_W-1:0] got_q[$];

  always #5 clk = ~clk;

  l2_req_out_packetizer #(
    .WORD_W(WORD_W), .WORDS_PER_LINE(WPL), .LINE_ADDR_W(LINE_ADDR_W),
    .TILE_ID_W(TILE_ID_W), .FLIT_W(FLIT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .l2_req_out_valid(l2_req_out_valid), .l2_req_out_ready(l2_req_out_ready),
    .l2_req_out_data_coh_msg(l2_req_out_data_coh_msg),
    .l2_req_out_data_hprot(l2_req_out_data_hprot),
    .l2_req_out_data_addr(l2_req_out_data_addr),
    .l2_req_out_data_line(l2_req_out_data_line),
    .cfg_src_id(cfg_src_id), .cfg_dst_id(cfg_dst_id),
    .noc_out_valid(noc_out_valid), .noc_out_ready(noc_out_ready),
    .noc_out_data(noc_out_data), .pkt_cnt(pkt_cnt)
  );

  // Record every flit the router side accepts (sampled mid-cycle).
  always @(negedge clk) begin
    if (!rst && noc_out_valid && noc_out_ready) got_q.push_back(noc_out_data);
  end

  // Expected packet for one request, built from the packet format.
  task automatic push_expected(input logic [1:0] msg, input logic [1:0] hprot,
                               input logic [LINE_ADDR_W-1:0] addr, input logic [LINE_W-1:0] line);
    logic [WORD_W-1:0] hp;
    logic [WORD_W-1:0] ap;
    hp        = '0;
    hp[1:0]   = msg;
    hp[2]     = hprot[0];
    hp[7:4]   = cfg_src_id;
    hp[11:8]  = cfg_dst_id;
    hp[15:12] = (msg == 2'd3) ? 4'(1 + WPL) : 4'd1;
    ap        = '0;
    ap[LINE_ADDR_W-1:0] = addr;
    exp_q.push_back({1'b0, 1'b1, hp});
    exp_q.push_back({msg != 2'd3, 1'b0, ap});
    if (msg == 2'd3)
      for (int w = 0; w < WPL; w++)
        exp_q.push_back({w == WPL - 1, 1'b0, line[w*WORD_W +: WORD_W]});
  endtask

  // Drive one request until it is taken; inputs are scrambled afterwards.
  task automatic send_req(input logic [1:0] msg, input logic [1:0] hprot,
                          input logic [LINE_ADDR_W-1:0] addr, input logic [LINE_W-1:0] line);
    bit done;
    done = 1'b0;
    push_expected(msg, hprot, addr, line);
    l2_req_out_valid        = 1'b1;
    l2_req_out_data_coh_msg = msg;
    l2_req_out_data_hprot   = hprot;
    l2_req_out_data_addr    = addr;
    l2_req_out_data_line    = line;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (l2_req_out_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    l2_req_out_valid        = 1'b0;
    l2_req_out_data_coh_msg = 2'($urandom);
    l2_req_out_data_hprot   = 2'($urandom);
    l2_req_out_data_addr    = LINE_ADDR_W'($urandom);
    l2_req_out_data_line    = {$urandom, $urandom, $urandom, $urandom};
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL handshake got=no_ready required=ready_within_200"); end
  endtask

  // Wait until all queued flits have been accepted (no comparison here).
  task automatic wait_drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (got_q.size() >= exp_q.size()) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (l2_req_out_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b required=0", l2_req_out_ready); end
    n_checks++; if (noc_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b required=0", noc_out_valid); end
    n_checks++; if (noc_out_data !== '0) begin n_fail++; $display("FAIL rst_data got=%h required=0", noc_out_data); end
    n_checks++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got=%h required=0", pkt_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    n_checks++; if (l2_req_out_ready !== 1'b0) begin n_fail++; $display("FAIL rel_ready_early got=%b required=0", l2_req_out_ready); end
    @(negedge clk);
    n_checks++; if (l2_req_out_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready got=%b required=1", l2_req_out_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_gets();
    bit ok;
    logic [FLIT_W-1:0] e, g;
    noc_out_ready = 1'b1;
    send_req(2'd0, 2'b01, 28'h1234567, {$urandom, $urandom, $urandom, $urandom});
    n_checks++; if (noc_out_valid !== 1'b1 || noc_out_data !== {2'b01, 64'h1534})
      begin n_fail++; $display("FAIL gets_head_latency got=%b/%h required=1/%h", noc_out_valid, noc_out_data, {2'b01, 64'h1534}); end
    wait_drain(50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL gets_drain got=%0d flits required=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL gets_flit got=%h required=%h", g, e); end
    end
    exp_cnt = exp_cnt + 16'd1;
    n_checks++; if (pkt_cnt !== exp_cnt) begin n_fail++; $display("FAIL gets_cnt got=%h required=%h", pkt_cnt, exp_cnt); end
  endtask

  task automatic test_putm();
    bit ok;
    logic [FLIT_W-1:0] e, g;
    noc_out_ready = 1'b1;
    send_req(2'd3, 2'b10, 28'hABCDEF0, {64'hBBBB, 64'hAAAA});
    n_checks++; if (noc_out_data !== {2'b01, 64'h3533})
      begin n_fail++; $display("FAIL putm_head got=%h required=%h", noc_out_data, {2'b01, 64'h3533}); end
    wait_drain(50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL putm_drain got=%0d flits required=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL putm_flit got=%h required=%h", g, e); end
    end
    exp_cnt = exp_cnt + 16'd1;
    n_checks++; if (pkt_cnt !== exp_cnt) begin n_fail++; $display("FAIL putm_cnt got=%h required=%h", pkt_cnt, exp_cnt); end
  endtask

  task automatic test_stall();
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    bit stalled;
    logic [FLIT_W-1:0] hold, e, g;
    stalled = 1'b0;
    hold    = '0;
    send_req(2'd3, 2'b01, 28'h0FEDCBA, {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888});
    for (int c = 0; c < 80 && got_q.size() < exp_q.size(); c++) begin
      noc_out_ready = pat[c % 4];
      @(negedge clk);
      if (stalled) begin
        n_checks++;
        if (noc_out_valid !== 1'b1 || noc_out_data !== hold)
          begin n_fail++; $display("FAIL stall_hold got=%b/%h required=1/%h", noc_out_valid, noc_out_data, hold); end
      end
      stalled = noc_out_valid && !noc_out_ready;
      hold    = noc_out_data;
      n_checks++; if (l2_req_out_ready !== 1'b0) begin n_fail++; $display("FAIL stall_req_ready got=%b required=0", l2_req_out_ready); end
      @(posedge clk); #1;
    end
    noc_out_ready = 1'b1;
    n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL stall_drain got=%0d flits required=%0d", got_q.size(), exp_q.size()); end
    n_checks++; if (l2_req_out_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready_after got=%b required=1", l2_req_out_ready); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL stall_flit got=%h required=%h", g, e); end
    end
    exp_cnt = exp_cnt + 16'd1;
    n_checks++; if (pkt_cnt !== exp_cnt) begin n_fail++; $display("FAIL stall_cnt got=%h required=%h", pkt_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    int cyc, t_tail, t_head2, hs;
    bit take;
    logic [FLIT_W-1:0] e, g;
    cyc = 0; t_tail = -1; t_head2 = -1; hs = 0;
    noc_out_ready = 1'b1;
    push_expected(2'd1, 2'b00, 28'h0000111, '0);
    push_expected(2'd1, 2'b01, 28'h0000222, '0);
    l2_req_out_valid        = 1'b1;
    l2_req_out_data_coh_msg = 2'd1;
    l2_req_out_data_hprot   = 2'b00;
    l2_req_out_data_addr    = 28'h0000111;
    for (int c = 0; c < 60 && !(hs == 2 && got_q.size() >= exp_q.size()); c++) begin
      @(negedge clk);
      cyc++;
      if (t_tail < 0 && noc_out_valid && noc_out_ready && noc_out_data[FLIT_W-1]) t_tail = cyc;
      if (t_tail >= 0 && cyc == t_tail + 1) begin
        n_checks++; if (l2_req_out_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got=%b required=1", l2_req_out_ready); end
      end
      if (t_tail >= 0 && t_head2 < 0 && noc_out_valid && noc_out_data[FLIT_W-2]) t_head2 = cyc;
      take = l2_req_out_valid && l2_req_out_ready;
      @(posedge clk); #1;
      if (take) begin
        hs++;
        if (hs == 1) begin l2_req_out_data_addr = 28'h0000222; l2_req_out_data_hprot = 2'b01; end
        else l2_req_out_valid = 1'b0;
      end
    end
    l2_req_out_valid = 1'b0;
    n_checks++; if (t_tail < 0 || t_head2 - t_tail != 2)
      begin n_fail++; $display("FAIL b2b_bubble got=%0d cycles required=2", t_head2 - t_tail); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL b2b_flit got=%h required=%h", g, e); end
    end
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing got=%0d left required=0", exp_q.size()); end
    exp_cnt = exp_cnt + 16'd2;
    n_checks++; if (pkt_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt got=%h required=%h", pkt_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_packet();
    bit ok;
    logic [FLIT_W-1:0] e, g;
    noc_out_ready = 1'b1;
    send_req(2'd3, 2'b00, 28'h0000ABC, {64'hDEAD, 64'hBEEF});
    @(posedge clk); @(posedge clk); #2;
    n_checks++; if (noc_out_data !== {2'b00, 64'hBEEF}) begin n_fail++; $display("FAIL mid_in_data got=%h required=%h", noc_out_data, {2'b00, 64'hBEEF}); end
    rst = 1'b1;
    #1;
    n_checks++; if (noc_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%b required=0", noc_out_valid); end
    n_checks++; if (pkt_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_cnt got=%h required=0", pkt_cnt); end
    exp_q.delete(); got_q.delete();
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send_req(2'd0, 2'b01, 28'h1234567, '0);
    n_checks++; if (noc_out_valid !== 1'b1 || noc_out_data !== {2'b01, 64'h1534})
      begin n_fail++; $display("FAIL mid_fresh_head got=%b/%h required=1/%h", noc_out_valid, noc_out_data, {2'b01, 64'h1534}); end
    wait_drain(50, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_drain got=%0d flits required=%0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL mid_flit got=%h required=%h", g, e); end
    end
    exp_cnt = exp_cnt + 16'd1;
    n_checks++; if (pkt_cnt !== exp_cnt) begin n_fail++; $display("FAIL mid_cnt_after got=%h required=%h", pkt_cnt, exp_cnt); end
  endtask

  task automatic test_cnt_wrap();
    bit ok;
    logic [FLIT_W-1:0] e, g;
    noc_out_ready = 1'b1;
    @(negedge clk);
    force dut.pkt_cnt = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.pkt_cnt;
    @(posedge clk); #1;
    exp_cnt = 16'hFFFE;
    for (int k = 0; k < 2; k++) begin
      send_req(2'd2, 2'b01, LINE_ADDR_W'($urandom), '0);
      wait_drain(50, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_drain got=%0d flits required=%0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
        e = exp_q.pop_front(); g = got_q.pop_front();
        n_checks++; if (g !== e) begin n_fail++; $display("FAIL wrap_flit got=%h required=%h", g, e); end
      end
      exp_cnt = exp_cnt + 16'd1;
      n_checks++; if (pkt_cnt !== exp_cnt) begin n_fail++; $display("FAIL wrap_cnt got=%h required=%h", pkt_cnt, exp_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_gets();
    test_putm();
    test_stall();
    test_back_to_back();
    test_reset_mid_packet();
    test_cnt_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
